// File: rtl/snn_pkt_pkg.sv
// rtl/snn_pkt_pkg.sv - shared constants and helpers for the spike-packet merge blocks
package snn_pkt_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Keeps a tag at least one bit wide even for degenerate channel counts.
  function automatic int idWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pkt_fifo2.sv
// rtl/pkt_fifo2.sv - 2-entry synchronous FIFO, generic width, head driven from registers
module pkt_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  output logic             full,
  output logic             popValid,
  output logic [WIDTH-1:0] popData,
  input  logic             popReady
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic             doPop;

  assign full     = (count == 2'd2);
  assign popValid = (count != 2'd0);
  assign popData  = mem[head];
  assign doPop    = popValid && popReady;

  // Storage is cleared too so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (pushValid) begin
        mem[tail] <= pushData;
        tail      <= ~tail;
      end
      if (doPop) begin
        head <= ~head;
      end
      count <= count + 2'(pushValid) - 2'(doPop);
    end
  end

endmodule

// File: rtl/packet_rr_merge.sv
// rtl/packet_rr_merge.sv - N-input packet merge: round-robin or aged fixed priority into a 2-entry FIFO
module packet_rr_merge
  import snn_pkt_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 31,
  parameter int ID_WIDTH   = idWidth(NUM_IN),
  parameter int MODE       = MODE_RR,
  parameter int AGE_LIMIT  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ID_WIDTH-1:0]          out_src,
  input  logic                         out_ready
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   src;
    logic [DATA_WIDTH-1:0] data;
  } pkt_entry_t;

  logic [DATA_WIDTH-1:0] inWord [NUM_IN];
  logic [7:0]            age    [NUM_IN];
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   grantIdx;
  logic [ID_WIDTH-1:0]   cand;
  logic                  grantAny;
  logic                  fifoFull;
  logic                  push;
  int                    idx;
  pkt_entry_t            pushEntry;
  pkt_entry_t            headEntry;

  for (genvar g = 0; g < NUM_IN; g++) begin : gSlice
    assign inWord[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Loops run from the highest candidate down so the preferred one is written last.
  always_comb begin
    grantIdx = '0;
    grantAny = 1'b0;
    cand     = '0;
    idx      = 0;
    if (MODE == MODE_FIXED) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grantIdx = ID_WIDTH'(i);
          grantAny = 1'b1;
        end
      end
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (in_valid[i] && age[i] == 8'(AGE_LIMIT)) begin
          grantIdx = ID_WIDTH'(i);
        end
      end
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_IN) begin
          idx = idx - NUM_IN;
        end
        cand = ID_WIDTH'(idx);
        if (in_valid[cand]) begin
          grantIdx = cand;
          grantAny = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grantAny && !fifoFull && !rst) begin
      in_ready[grantIdx] = 1'b1;
    end
  end

  assign push      = |in_ready;
  assign pushEntry = '{src: grantIdx, data: inWord[grantIdx]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= (grantIdx == ID_WIDTH'(NUM_IN - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

  // A waiting input only ages while the FIFO could have taken it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (rst || !in_valid[i] || in_ready[i]) begin
        age[i] <= 8'd0;
      end else if (!fifoFull && age[i] != 8'(AGE_LIMIT)) begin
        age[i] <= age[i] + 8'd1;
      end
    end
  end

  pkt_fifo2 #(
    .WIDTH($bits(pkt_entry_t))
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .pushValid(push),
    .pushData (pushEntry),
    .full     (fifoFull),
    .popValid (out_valid),
    .popData  (headEntry),
    .popReady (out_ready)
  );

  assign out_data = headEntry.data;
  assign out_src  = headEntry.src;

endmodule

// File: tb/tb_packet_rr_merge.sv
// tb/tb_packet_rr_merge.sv - scoreboard bench for packet_rr_merge in round-robin and aged-priority modes
module tb_packet_rr_merge;

  localparam int N   = 4;
  localparam int DW  = 31;
  localparam int IW  = 2;
  localparam int LIM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    inValid  [2];
  logic [N*DW-1:0] inData   [2];
  logic [N-1:0]    inReady  [2];
  logic            outValid [2];
  logic [DW-1:0]   outData  [2];
  logic [IW-1:0]   outSrc   [2];
  logic            outReady [2];

  packet_rr_merge #(.NUM_IN(N), .DATA_WIDTH(DW), .MODE(0)) dutRr (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_data(inData[0]), .in_ready(inReady[0]),
    .out_valid(outValid[0]), .out_data(outData[0]), .out_src(outSrc[0]), .out_ready(outReady[0]));

  packet_rr_merge #(.NUM_IN(N), .DATA_WIDTH(DW), .MODE(1), .AGE_LIMIT(LIM)) dutAge (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_data(inData[1]), .in_ready(inReady[1]),
    .out_valid(outValid[1]), .out_data(outData[1]), .out_src(outSrc[1]), .out_ready(outReady[1]));

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Reference state: expected FIFO contents, occupancy, rr pointer and per-input wait counts.
  logic [IW+DW-1:0] expQ0[$];
  logic [IW+DW-1:0] expQ1[$];
  int srcLog0[$];
  int srcLog1[$];
  int ptrM [2] = '{0, 0};
  int occM [2] = '{0, 0};
  int ageM [2][N];
  int granted [2] = '{-1, -1};
  int accCount = 0;

  task automatic check(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %0h expected %0h", name, m, act, exp);
    end
  endtask

  function automatic int expGrant(input int m);
    if (rst || occM[m] == 2) return -1;
    if (m == 1) begin
      for (int i = 0; i < N; i++) if (inValid[m][i] && ageM[m][i] == LIM) return i;
      for (int i = 0; i < N; i++) if (inValid[m][i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (inValid[m][(ptrM[m] + k) % N]) return (ptrM[m] + k) % N;
    end
    return -1;
  endfunction

  int gM;
  bit popM;
  logic [N-1:0] expReadyM;

  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        gM = expGrant(m);
        expReadyM = (gM >= 0) ? (N'(1) << gM) : '0;
        check("in_ready", m, 64'(inReady[m]), 64'(expReadyM));
        check("out_valid", m, 64'(outValid[m]), 64'(occM[m] != 0));
        granted[m] = gM;
        if (rst) begin
          ptrM[m] = 0;
          occM[m] = 0;
          for (int i = 0; i < N; i++) ageM[m][i] = 0;
          if (m == 0) expQ0.delete(); else expQ1.delete();
        end else begin
          popM = (occM[m] != 0) && outReady[m];
          for (int i = 0; i < N; i++) begin
            if (!inValid[m][i] || i == gM) ageM[m][i] = 0;
            else if (occM[m] != 2 && ageM[m][i] < LIM) ageM[m][i]++;
          end
          if (gM >= 0) begin
            ptrM[m] = (gM + 1) % N;
            if (m == 0) expQ0.push_back({IW'(gM), inData[m][gM*DW +: DW]});
            else        expQ1.push_back({IW'(gM), inData[m][gM*DW +: DW]});
          end
          occM[m] = occM[m] + ((gM >= 0) ? 1 : 0) - (popM ? 1 : 0);
        end
      end
    end
  end

  logic [IW+DW-1:0] eMon;
  bit haveMon;

  always @(negedge clk) begin
    if (started && !rst) begin
      if (|inReady[0]) accCount++;
      for (int m = 0; m < 2; m++) begin
        if (outValid[m] === 1'b1 && outReady[m]) begin
          haveMon = (m == 0) ? (expQ0.size() != 0) : (expQ1.size() != 0);
          if (!haveMon) begin
            check("spurious out_valid", m, 64'(outValid[m]), 64'(0));
          end else begin
            if (m == 0) eMon = expQ0.pop_front(); else eMon = expQ1.pop_front();
            check("out_src", m, 64'(outSrc[m]), 64'(eMon[IW+DW-1:DW]));
            check("out_data", m, 64'(outData[m]), 64'(eMon[DW-1:0]));
            if (m == 0) srcLog0.push_back(int'(outSrc[0]));
            else        srcLog1.push_back(int'(outSrc[1]));
          end
        end
      end
    end
  end

  task automatic refresh();
    for (int m = 0; m < 2; m++)
      if (granted[m] >= 0) inData[m][granted[m]*DW +: DW] = DW'($urandom);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      refresh();
    end
  endtask

  task automatic checkLog(input string name, input int m, input int exp[$]);
    int sz;
    sz = (m == 0) ? srcLog0.size() : srcLog1.size();
    check({name, " count"}, m, 64'(sz), 64'(exp.size()));
    for (int i = 0; i < sz && i < exp.size(); i++)
      check(name, m, 64'((m == 0) ? srcLog0[i] : srcLog1[i]), 64'(exp[i]));
  endtask

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      inValid[m]  = '1;
      outReady[m] = 1'b1;
      for (int i = 0; i < N; i++) inData[m][i*DW +: DW] = DW'($urandom);
    end
    @(posedge clk);
    #1;
    started = 1'b1;
    cyc(2);

    // Round-robin with every input busy.
    rst = 1'b0;
    inValid[1] = '0;
    srcLog0.delete();
    cyc(8);
    inValid[0] = '0;
    cyc(1);
    checkLog("rr order", 0, '{0, 1, 2, 3, 0, 1, 2, 3});

    // Back-pressure: two accepts then stall until the head drains.
    srcLog0.delete();
    accCount = 0;
    outReady[0] = 1'b0;
    inValid[0] = 4'b0101;
    cyc(5);
    check("bp accepts", 0, 64'(accCount), 64'(2));
    check("bp stall in_ready", 0, 64'(inReady[0]), 64'(0));
    check("bp nothing out", 0, 64'(srcLog0.size()), 64'(0));
    outReady[0] = 1'b1;
    inValid[0] = '0;
    cyc(3);
    checkLog("bp drain", 0, '{0, 2});
    check("bp no extra", 0, 64'(accCount), 64'(2));

    // Reset while the FIFO holds two packets.
    outReady[0] = 1'b0;
    inValid[0] = 4'b0101;
    cyc(4);
    check("full before reset", 0, 64'(outValid[0]), 64'(1));
    rst = 1'b1;
    inValid[0] = '0;
    cyc(1);
    check("reset flush", 0, 64'(outValid[0]), 64'(0));
    rst = 1'b0;
    srcLog0.delete();
    outReady[0] = 1'b1;
    inValid[0] = '1;
    cyc(1);
    inValid[0] = '0;
    cyc(2);
    checkLog("post-reset grant", 0, '{0});

    // Sparse round-robin, then a late input 0.
    srcLog0.delete();
    inValid[0] = 4'b1010;
    cyc(4);
    inValid[0] = 4'b1011;
    cyc(1);
    inValid[0] = '0;
    cyc(2);
    checkLog("sparse rr", 0, '{1, 3, 1, 3, 0});

    // Fixed priority with aging on input 1.
    srcLog1.delete();
    outReady[1] = 1'b1;
    inValid[1] = 4'b0011;
    cyc(8);
    inValid[1] = '0;
    cyc(2);
    checkLog("aging", 1, '{0, 0, 0, 1, 0, 0, 0, 1});

    // Random traffic on both instances, with occasional resets.
    for (int t = 0; t < 400; t++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          if (inValid[m][i] && granted[m] != i) begin
            if ($urandom_range(0, 7) == 0) inValid[m][i] = 1'b0;
          end else begin
            if (!inValid[m][i]) inData[m][i*DW +: DW] = DW'($urandom);
            inValid[m][i] = ($urandom_range(0, 2) != 0);
          end
        end
        outReady[m] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc(1);
    end

    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      inValid[m]  = '0;
      outReady[m] = 1'b1;
    end
    cyc(4);
    check("rr drained", 0, 64'(expQ0.size()), 64'(0));
    check("age drained", 1, 64'(expQ1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
